// File: rtl/comma_align_ctrl.sv
// Comma alignment controller: finds K28.5 in a raw 10b stream, locks onto its bit offset
// and emits realigned symbols once three in-phase commas have been seen.
module comma_align_ctrl #(
    parameter int unsigned MAX_GAP = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] in_10b,
    input  logic       in_valid,
    output logic [9:0] aligned_10b,
    output logic       aligned_valid,
    output logic       is_k,
    output logic       sync_ok,
    output logic [3:0] lock_off,
    output logic [1:0] dbg_state_o,
    output logic [1:0] dbg_err_cnt_o
);
    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;
    localparam logic [9:0] GAP_LIMIT = 10'(MAX_GAP);

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_ACQ1 = 2'd1,
        ST_ACQ2 = 2'd2,
        ST_SYNC = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [9:0] prev_word_q;
    logic [3:0] lock_off_q, lock_off_d;
    logic [1:0] err_cnt_q, err_cnt_d;
    logic [9:0] gap_cnt_q, gap_cnt_d;
    logic [9:0] aligned_q, aligned_d;
    logic       aligned_valid_q, aligned_valid_d;
    logic       is_k_q, is_k_d;
    logic       sync_ok_q, sync_ok_d;

    logic [19:0] window;
    logic [9:0]  slices [10];
    logic        comma_hit;
    logic [3:0]  hit_off;
    logic        in_phase;
    logic [9:0]  gap_inc;

    function automatic logic is_comma(input logic [9:0] s);
        return (s == K28_5_RDN) || (s == K28_5_RDP);
    endfunction

    // Descending scan so the lowest matching offset wins.
    always_comb begin
        window    = {prev_word_q, in_10b};
        comma_hit = 1'b0;
        hit_off   = '0;
        for (int k = 9; k >= 0; k--) begin
            slices[k] = window[k +: 10];
            if (is_comma(window[k +: 10])) begin
                comma_hit = 1'b1;
                hit_off   = 4'(k);
            end
        end
    end

    assign in_phase = comma_hit && (hit_off == lock_off_q);
    assign gap_inc  = gap_cnt_q + 10'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_LOS;
            prev_word_q     <= '0;
            lock_off_q      <= '0;
            err_cnt_q       <= '0;
            gap_cnt_q       <= '0;
            aligned_q       <= '0;
            aligned_valid_q <= 1'b0;
            is_k_q          <= 1'b0;
            sync_ok_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            lock_off_q      <= lock_off_d;
            err_cnt_q       <= err_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            aligned_q       <= aligned_d;
            aligned_valid_q <= aligned_valid_d;
            is_k_q          <= is_k_d;
            sync_ok_q       <= sync_ok_d;
            if (in_valid) begin
                prev_word_q <= in_10b;
            end
        end
    end

    // Nothing advances without in_valid; the gap timeout overrides any comma decision.
    always_comb begin
        state_d    = state_q;
        lock_off_d = lock_off_q;
        err_cnt_d  = err_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        if (in_valid) begin
            case (state_q)
                ST_LOS: begin
                    if (comma_hit) begin
                        lock_off_d = hit_off;
                        state_d    = ST_ACQ1;
                    end
                end
                ST_ACQ1: begin
                    if (in_phase) begin
                        state_d = ST_ACQ2;
                    end else if (comma_hit) begin
                        lock_off_d = hit_off;
                    end
                end
                ST_ACQ2: begin
                    if (in_phase) begin
                        state_d = ST_SYNC;
                    end else if (comma_hit) begin
                        lock_off_d = hit_off;
                        state_d    = ST_ACQ1;
                    end
                end
                ST_SYNC: begin
                    if (in_phase) begin
                        err_cnt_d = '0;
                    end else if (comma_hit) begin
                        if (err_cnt_q == 2'd3) begin
                            state_d = ST_LOS;
                        end else begin
                            err_cnt_d = err_cnt_q + 2'd1;
                        end
                    end
                end
                default: state_d = ST_LOS;
            endcase
            if (state_q != ST_LOS) begin
                if (in_phase) begin
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_inc;
                    if (gap_inc >= GAP_LIMIT) begin
                        state_d = ST_LOS;
                    end
                end
            end
            if (state_d == ST_LOS) begin
                err_cnt_d = '0;
                gap_cnt_d = '0;
            end
        end
    end

    // in_valid qualifies in_10b for one cycle; aligned_valid qualifies aligned_10b one cycle later.
    always_comb begin
        aligned_d       = aligned_q;
        is_k_d          = is_k_q;
        aligned_valid_d = 1'b0;
        sync_ok_d       = (state_d == ST_SYNC);
        if (in_valid) begin
            aligned_d       = slices[lock_off_d];
            is_k_d          = is_comma(slices[lock_off_d]);
            aligned_valid_d = (state_d == ST_SYNC);
        end
    end

    assign aligned_10b   = aligned_q;
    assign aligned_valid = aligned_valid_q;
    assign is_k          = is_k_q;
    assign sync_ok       = sync_ok_q;
    assign lock_off      = lock_off_q;
    assign dbg_state_o   = state_q;
    assign dbg_err_cnt_o = err_cnt_q;

endmodule
